// File: rtl/reg_wb_scheduler_pkg.sv
// Shared types for the register writeback scheduler: source select and register index width.
// No logic; imported by the top and the scoreboard.
package reg_wb_scheduler_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // Pointer holds the most recent winner; starting at ALU hands MEM the first contention.
  localparam src_e PTR_RST = SRC_ALU;

endpackage

// File: rtl/reg_wb_scheduler_scoreboard.sv
// Pending-destination scoreboard: set on issue, clear on register-file write, set wins a tie.
// busy_mask is registered; hazard is a combinational lookup with no backpressure.
module reg_scoreboard
  import reg_wb_scheduler_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  reg_idx_t        set_rd,
  input  logic            clr_en,
  input  reg_idx_t        clr_rd,
  input  reg_idx_t        rs1,
  input  reg_idx_t        rs2,
  output logic            hazard,
  output logic [NREG-1:0] busy_mask
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clear first so a same-register issue at the same edge overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_rd] = 1'b0;
    end
    if (set_en && (set_rd != '0)) begin
      busy_d[set_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_mask = busy_q;
  assign hazard    = busy_q[rs1] | busy_q[rs2];

endmodule

// File: rtl/reg_wb_scheduler.sv
// Round-robin arbiter of ALU and load writebacks onto one register-file write port, plus scoreboard.
// Latency 1 cycle to rf_we; the losing requester sees ready=0 and holds its request.
module reg_wb_scheduler
  import reg_wb_scheduler_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            hazard,
  output logic [NREG-1:0] busy_mask
);

  src_e            ptr_q;
  src_e            ptr_d;
  logic            rf_we_q;
  logic            rf_we_d;
  reg_idx_t        rf_rd_q;
  reg_idx_t        rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q;
  logic [XLEN-1:0] rf_wdata_d;
  logic            alu_acc;
  logic            mem_acc;

  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!rst) begin
      if (alu_valid && mem_valid) begin
        alu_ready = (ptr_q == SRC_MEM);
        mem_ready = (ptr_q == SRC_ALU);
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
  end

  assign alu_acc = alu_valid & alu_ready;
  assign mem_acc = mem_valid & mem_ready;

  // x0 writes still handshake but never reach the register file.
  always_comb begin
    ptr_d      = ptr_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = '0;
    rf_wdata_d = '0;
    if (alu_acc) begin
      ptr_d      = SRC_ALU;
      rf_we_d    = (alu_rd != '0);
      rf_rd_d    = alu_rd;
      rf_wdata_d = alu_data;
    end else if (mem_acc) begin
      ptr_d      = SRC_MEM;
      rf_we_d    = (mem_rd != '0);
      rf_rd_d    = mem_rd;
      rf_wdata_d = mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= PTR_RST;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

  reg_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_valid),
    .set_rd   (iss_rd),
    .clr_en   (rf_we_q),
    .clr_rd   (rf_rd_q),
    .rs1      (chk_rs1),
    .rs2      (chk_rs2),
    .hazard   (hazard),
    .busy_mask(busy_mask)
  );

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Bench for reg_wb_scheduler: directed scenarios with literal expectations, then randomized traffic
// checked each cycle against a behavioural model (busy array, last-winner flag, pending write).
module tb_reg_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, iss_valid;
  logic [4:0]  alu_rd, mem_rd, iss_rd, chk_rs1, chk_rs2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, rf_we, hazard;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata, busy_mask;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  bit [31:0] m_busy;
  bit        m_last_mem;   // 1: MEM won the most recent accepted request
  bit        m_we;
  bit [4:0]  m_rd;
  bit [31:0] m_data;
  bit        acc_alu, acc_mem;

  always #5 clk = ~clk;

  reg_wb_scheduler #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
    .busy_mask(busy_mask)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_last_mem = 1'b0; m_we = 1'b0; m_rd = '0; m_data = '0;
    acc_alu = 1'b0; acc_mem = 1'b0;
  endtask

  // 0 none, 1 ALU, 2 MEM
  function automatic int winner();
    if (rst) return 0;
    if (alu_valid && mem_valid) return m_last_mem ? 1 : 2;
    if (alu_valid) return 1;
    if (mem_valid) return 2;
    return 0;
  endfunction

  task automatic compare_outputs();
    int w;
    w = winner();
    chk("alu_ready", alu_ready, (w == 1) ? 32'd1 : 32'd0);
    chk("mem_ready", mem_ready, (w == 2) ? 32'd1 : 32'd0);
    chk("rf_we", rf_we, m_we);
    if (m_we) begin
      chk("rf_rd", rf_rd, m_rd);
      chk("rf_wdata", rf_wdata, m_data);
    end
    chk("busy_mask", busy_mask, m_busy);
    chk("hazard", hazard, m_busy[chk_rs1] | m_busy[chk_rs2]);
  endtask

  // Advance the model across the coming rising edge.
  task automatic model_edge();
    int w;
    w = winner();
    if (rst) begin
      model_reset();
      return;
    end
    if (m_we) m_busy[m_rd] = 1'b0;
    if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    acc_alu = (w == 1);
    acc_mem = (w == 2);
    m_we = 1'b0;
    if (w == 1) begin
      m_we = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data; m_last_mem = 1'b0;
    end else if (w == 2) begin
      m_we = (mem_rd != 0); m_rd = mem_rd; m_data = mem_data; m_last_mem = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; iss_valid = 0;
    alu_rd = 0; mem_rd = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    alu_data = 0; mem_data = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_rf_we", rf_we, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] seq [4];
    idle_inputs();
    model_reset();
    do_reset();
    alu_valid = 1; mem_valid = 1;
    #1;
    chk("rst_release_ready", {31'd0, alu_ready | mem_ready}, 32'd1);
    idle_inputs();
    cycle();

    // Single ALU request, latency 1.
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    chk("single_alu_ready", alu_ready, 32'd1);
    chk("single_mem_ready", mem_ready, 32'd0);
    cycle();
    alu_valid = 0;
    chk("single_rf_we", rf_we, 32'd1);
    chk("single_rf_rd", rf_rd, 32'd5);
    chk("single_rf_wdata", rf_wdata, 32'hDEADBEEF);
    cycle();

    // Contention right after reset: MEM, ALU, MEM, ALU.
    do_reset();
    seq[0] = 5'd2; seq[1] = 5'd1; seq[2] = 5'd2; seq[3] = 5'd1;
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA1A1A1A1;
    mem_valid = 1; mem_rd = 2; mem_data = 32'hB2B2B2B2;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_rf_we", rf_we, 32'd1);
      chk("rr_rf_rd", rf_rd, seq[i]);
    end
    idle_inputs();
    cycle();

    // Issue then write back the same register.
    iss_valid = 1; iss_rd = 7;
    cycle();
    iss_valid = 0; chk_rs1 = 7;
    #1;
    chk("haz_set", hazard, 32'd1);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    cycle();
    alu_valid = 0;
    chk("haz_still_busy", busy_mask[7], 32'd1);
    cycle();
    chk("haz_clear_busy", busy_mask[7], 32'd0);
    chk("haz_clear", hazard, 32'd0);

    // Set wins over clear on the same register.
    iss_valid = 1; iss_rd = 9;
    cycle();
    iss_valid = 0; mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
    cycle();
    mem_valid = 0; iss_valid = 1; iss_rd = 9;
    cycle();
    iss_valid = 0;
    chk("set_wins", busy_mask[9], 32'd1);
    cycle();

    // Register 0: never busy, write suppressed, handshake completes.
    do_reset();
    iss_valid = 1; iss_rd = 0; alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
    #1;
    chk("x0_ready", alu_ready, 32'd1);
    cycle();
    idle_inputs();
    chk("x0_rf_we", rf_we, 32'd0);
    chk("x0_busy", busy_mask, 32'd0);
    cycle();

    // Async reset one cycle after an acceptance.
    iss_valid = 1; iss_rd = 4; alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    cycle();
    idle_inputs();
    chk("pre_arst_we", rf_we, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_rf_we", rf_we, 32'd0);
    chk("arst_busy", busy_mask, 32'd0);
    chk("arst_wdata", rf_wdata, 32'd0);
    cycle();
    rst = 1'b0;
    cycle();

    // Randomized traffic; unaccepted requests are held stable.
    for (int n = 0; n < 3000; n++) begin
      if (!(alu_valid && !acc_alu)) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd = 5'($urandom_range(0, 15));
        alu_data = $urandom;
      end
      if (!(mem_valid && !acc_mem)) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd = 5'($urandom_range(0, 15));
        mem_data = $urandom;
      end
      iss_valid = ($urandom_range(0, 1) != 0);
      iss_rd = 5'($urandom_range(0, 15));
      chk_rs1 = 5'($urandom_range(0, 15));
      chk_rs2 = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_scheduler.md
REG_WB_SCHEDULER -- requirements
Module: reg_wb_scheduler

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: data width of register-file write data.
REQ-002 The block SHALL have parameter NREG, default 32: number of architectural registers, with register index width 5.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have ports alu_valid (in, 1), alu_rd (in, 5), alu_data (in, XLEN) and alu_ready (out, 1): the ALU writeback request channel.
REQ-006 The block SHALL have ports mem_valid (in, 1), mem_rd (in, 5), mem_data (in, XLEN) and mem_ready (out, 1): the load-unit writeback request channel.
REQ-007 The block SHALL have ports rf_we (out, 1), rf_rd (out, 5) and rf_wdata (out, XLEN): the register-file write port, all three registered.
REQ-008 The block SHALL have ports iss_valid (in, 1) and iss_rd (in, 5): instruction issue, marking a destination register pending.
REQ-009 The block SHALL have ports chk_rs1 (in, 5), chk_rs2 (in, 5) and hazard (out, 1): the combinational operand-hazard query.
REQ-010 The block SHALL have port busy_mask, output, NREG bits: the current scoreboard contents.

Function
REQ-011 A request SHALL be accepted in a cycle where valid and ready are both high at the rising edge; ready SHALL be combinational from the valids and the arbitration pointer only.
REQ-012 With exactly one valid request, that requester's ready SHALL be 1 and the other ready SHALL be 0.
REQ-013 With both requests valid, the block SHALL grant the source not granted most recently (round-robin).
REQ-014 The pointer SHALL update only on an accepted request; the reset value SHALL give MEM priority on the first contention.
REQ-015 An accepted request SHALL drive rf_we=1, rf_rd=rd and rf_wdata=data in the next cycle (latency 1); otherwise rf_we SHALL be 0.
REQ-016 An accepted request with rd=0 SHALL complete the handshake normally and SHALL produce rf_we=0.
REQ-017 An unaccepted request SHALL be held stable by the requester; the block SHALL NOT require the request to be withdrawn.
REQ-018 A rising edge with iss_valid=1 and iss_rd!=0 SHALL set busy_mask[iss_rd].
REQ-019 A rising edge with rf_we=1 SHALL clear busy_mask[rf_rd].
REQ-020 If the set (REQ-018) and clear (REQ-019) target the same register at the same edge, the set SHALL win.
REQ-021 busy_mask[0] SHALL always be 0.
REQ-022 hazard SHALL equal busy_mask[chk_rs1] OR busy_mask[chk_rs2], purely combinational; index 0 SHALL never raise hazard.
REQ-023 A write to a non-busy register SHALL be legal and SHALL leave busy_mask unchanged.

Reset
REQ-024 While rst=1 the block SHALL immediately force rf_we=0, rf_rd=0, rf_wdata=0, busy_mask=0 and the pointer to its reset value, independent of clk.
REQ-025 While rst=1, alu_ready and mem_ready SHALL be 0 and no request SHALL be accepted.
REQ-026 Reset asserted mid-operation SHALL discard any registered pending write.

Structure
REQ-027 The source-select encoding (SRC_ALU, SRC_MEM) and the register-index width SHALL be defined in a shared package.
REQ-028 The scoreboard SHALL be a separate sub-module, reg_scoreboard, containing the set/clear logic, busy_mask and the hazard lookup.

Verification
REQ-029 alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF, mem_valid=0 -> alu_ready=1 in the same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF.
REQ-030 Both channels valid for 4 consecutive cycles immediately after reset -> grants in the order MEM, ALU, MEM, ALU, with exactly one rf_we per cycle.
REQ-031 iss_valid=1, iss_rd=7, then chk_rs1=7 -> hazard=1; then an accepted write with rd=7 -> busy_mask[7]=0 and hazard=0 at the edge after rf_we.
REQ-032 iss_rd=9 issued at the same edge where rf_we=1 and rf_rd=9 -> busy_mask[9] remains 1.
REQ-033 iss_rd=0 issued, and a write with rd=0 accepted -> busy_mask=0, rf_we=0, handshake completes.
REQ-034 rst asserted asynchronously one cycle after an acceptance -> rf_we drops to 0 and busy_mask clears without waiting for a clock edge.
